// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit that owns the MIPS HI/LO registers.
// A MULT/MULTU/DIV/DIVU runs one bit per cycle on operand magnitudes.
// The sign is restored in a single FIX cycle, which also writes HI/LO back.
// stall_o holds a Decode-stage HI/LO consumer until the result is visible.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic             hilo_use_d,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    // Operation context captured at launch
    logic                   r_is_div;
    logic                   r_sign_q;
    logic                   r_sign_r;
    logic                   r_div0;
    logic [CW-1:0]          r_count;
    // Multiply: r_opnd = |multiplicand|, r_acc = {partial product, multiplier}.
    // Divide:   r_opnd = |divisor|,      r_acc = {remainder, quotient}.
    logic [WIDTH-1:0]       r_opnd;
    logic [2*WIDTH-1:0]     r_acc;

    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic                   r_done;

    logic                   w_launch;
    logic                   w_signed;
    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [WIDTH:0]         w_msum;
    logic [2*WIDTH-1:0]     w_mul_next;
    logic [WIDTH:0]         w_rem_sh;
    logic [WIDTH:0]         w_trial;
    logic [2*WIDTH-1:0]     w_div_next;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quot;
    logic [WIDTH-1:0]       w_rem;
    logic [WIDTH-1:0]       w_fix_hi;
    logic [WIDTH-1:0]       w_fix_lo;

    // Launch decode and operand magnitudes (signed ops only take |x|)
    assign w_launch = start_i & ~flush_i & (r_state == S_IDLE);
    assign w_signed = ~op_i[0];
    assign w_abs_a  = (w_signed & srca_i[WIDTH-1]) ? -srca_i : srca_i;
    assign w_abs_b  = (w_signed & srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;

    // Shift-add step: conditionally add into the upper half, carry shifts in
    assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + ({1'b0, r_opnd} & {(WIDTH+1){r_acc[0]}});
    assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

    // Restoring divide step: the shifted remainder needs one extra bit
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial    = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = {(w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], ~w_trial[WIDTH]};

    // Sign fix. Divide by zero leaves the remainder equal to |srca|, so the
    // remainder sign fix alone restores srca; only LO needs forcing.
    assign w_prod   = r_sign_q ? -r_acc : r_acc;
    assign w_quot   = r_div0   ? {WIDTH{1'b1}}
                    : (r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem    = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaulting w_next first guarantees no latch on any path.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i & ~flush_i) w_next = S_RUN;
            S_RUN:   if (r_count == CW'(WIDTH-1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Iteration datapath: capture at launch, one bit per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath is reset too, so an aborted operation leaves no
        // stale context behind for the next launch.
        if (!rst_n) begin
            r_is_div <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
            r_count  <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
        end else if (w_launch) begin
            r_is_div <= op_i[1];
            r_sign_q <= w_signed & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
            r_sign_r <= w_signed & srca_i[WIDTH-1];
            r_div0   <= op_i[1] & (srcb_i == '0);
            r_count  <= '0;
            r_opnd   <= op_i[1] ? w_abs_b : w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, (op_i[1] ? w_abs_a : w_abs_b)};
        end else if (r_state == S_RUN) begin
            r_acc    <= r_is_div ? w_div_next : w_mul_next;
            r_count  <= r_count + CW'(1);
        end
    end

    // HI/LO: MTHI/MTLO in any state, FIX write-back takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            if (mthi_i) r_hi <= wdata_i;
            if (mtlo_i) r_lo <= wdata_i;
            if (r_state == S_FIX) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
            r_done <= (r_state == S_FIX);
        end
    end

    assign hi_o    = r_hi;
    assign lo_o    = r_lo;
    assign done_o  = r_done;
    assign busy_o  = (r_state != S_IDLE);
    assign stall_o = hilo_use_d & (busy_o | (start_i & ~flush_i));

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit for the 5-stage MIPS pipeline (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO).
- Owns the HI/LO registers and launches an operation from the Execute stage.
- Runs a shift-add multiply or restoring divide, one bit per cycle.
- Raises a stall request that the hazard unit ORs into StallF/StallD and FlushE while a Decode-stage instruction needs HI/LO.

Parameters:
- WIDTH, 32, operand/HI/LO width; also the iteration count.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  Execute-stage mult/div instruction valid.
- op_i  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
- flush_i  input  1  FlushE; a start in the same cycle is discarded.
- srca_i  input  WIDTH  rs operand (multiplicand/dividend).
- srcb_i  input  WIDTH  rt operand (multiplier/divisor).
- hilo_use_d  input  1  Decode-stage instruction is MFHI/MFLO/MULT*/DIV*/MTHI/MTLO.
- mthi_i  input  1  write HI from wdata_i.
- mtlo_i  input  1  write LO from wdata_i.
- wdata_i  input  WIDTH  MTHI/MTLO data.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse; new HI/LO first visible.
- stall_o  output  1  stall request to the hazard unit.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; hi_o, lo_o, count, internal accumulators = 0.
  - busy_o=0, done_o=0.
  - Takes effect immediately, including mid-operation. The aborted result is never written.
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN on start_i & ~flush_i.
  - Capture op_i and operand magnitudes. Signed ops take two's-complement absolute values; unsigned ops take operands as-is.
  - Record sign_q = srca[MSB]^srcb[MSB] and sign_r = srca[MSB] (signed ops only); count=0.
- RUN, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH accumulator. Then shift the accumulator right 1.
- RUN, divide: each cycle, shift {rem,quot} left 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quot LSB=1.
- count increments each RUN cycle. RUN → FIX after WIDTH cycles (count==WIDTH-1).
- FIX:
  - Apply the sign fix. Product is negated if sign_q. Quotient is negated if sign_q. Remainder is negated if sign_r.
  - Write HI=product[2W-1:W] / remainder and LO=product[W-1:0] / quotient.
  - → IDLE; done_o registered high for the next cycle only.
- Latency: start accepted in cycle c; busy_o=1 in cycles c+1..c+WIDTH+1. New HI/LO and done_o=1 in cycle c+WIDTH+2 (34 cycles for WIDTH=32).
- Divide by zero (srcb_i=0, signed or unsigned): HI=srca_i unmodified, LO=all ones. Latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- stall_o = hilo_use_d & (busy_o | (start_i & ~flush_i)). It is combinational, with no dependence on the result.
- start_i while busy_o=1: ignored, with no effect on the running operation. This cannot occur under correct stalling; the bench flags it as an error.
- MTHI/MTLO:
  - Write at the clock edge in any state.
  - If the FIX write-back occurs at the same edge, the FIX result wins for that register.
  - mthi_i and mtlo_i together write both registers.
- hi_o/lo_o hold their values while RUN; intermediate state is never exposed.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=5, start in cycle c → busy_o cycles c+1..c+33; cycle c+34: HI=0xFFFFFFFF, LO=0xFFFFFFF1, done_o=1 for one cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. DIVU 100/7 → LO=14, HI=2.
- DIV 0xFFFFFFF9 (-7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 7/0 → HI=7, LO=0xFFFFFFFF at c+34. Same with start_i & flush_i both high → no state change, busy_o stays 0.
- hilo_use_d held high from cycle c → stall_o=1 in cycles c..c+33, 0 at c+34. mtlo_i with 0x1234 at the FIX edge → LO shows the multiply result, not 0x1234.
- rst_n pulsed low in cycle c+10 of a MULT → busy_o=0 and HI=LO=0 immediately; no done_o. A fresh MULTU 3×4 afterwards → LO=12.
